ripple_cnt_seq: RTL and testbench
=================================

Name: ripple_cnt_seq

Overview:
- Synchronous controller that sequences an external 4-bit ripple counter built from negedge T flip-flops.
- Generates the counter's trigger pulses and drives the counter's async reset.
- Waits for ripple settle, samples the counter through a synchronizer and checks each step against an expected value.
- Runs in the system clock domain; one instance sits beside each ripple counter in the counter subsystem.

Parameters:
- CNT_W, 4, width of counter, target and sample.
- PULSE_W, 2, cycles cnt_trig is held high per increment (≥1).
- SETTLE_CYC, 4, wait cycles after each trigger falling edge or clear release before sampling (≥3; covers 2-flop sync plus ripple).
- CLR_CYC, 2, cycles cnt_rstn is held low during clear (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  request a run; accepted only in IDLE.
- stop  in  1  abort the current run.
- target  in  CNT_W  final count; latched when start is accepted.
- cnt_in  in  CNT_W  counter outputs (asynchronous to clk).
- cnt_trig  out  1  counter trigger; the counter advances on its falling edge.
- cnt_rstn  out  1  counter reset, active-low.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse, run finished (normal end or error).
- abort  out  1  one-cycle pulse, run killed by stop.
- err  out  1  sticky: sampled count mismatched the expected count.
- sample  out  CNT_W  last synchronized counter value taken in CHECK.

Behaviour:
- All outputs are registered.
- Reset values:
  - cnt_trig=0, cnt_rstn=0 (counter held in reset), busy=0, done=0, abort=0, err=0, sample=0.
  - State IDLE; expected=0; target latch=0; synchronizer flops=0.
- cnt_in passes through a 2-flop synchronizer per bit before any use.
- FSM states: IDLE, CLEAR, SETTLE, CHECK, PULSE_HI, PULSE_LO, DONE.
- IDLE:
  - cnt_rstn=1 (the counter keeps its last value); busy=0.
  - start=1 and stop=0 → latch target, clear err, expected=0, go to CLEAR.
- CLEAR: cnt_rstn=0 for CLR_CYC cycles, then cnt_rstn=1 and go to SETTLE.
- SETTLE: wait SETTLE_CYC cycles with cnt_trig=0, then go to CHECK.
- CHECK (1 cycle):
  - sample ← synchronized cnt_in.
  - If synced value ≠ expected → err=1, go to DONE.
  - Else if expected == target → go to DONE.
  - Else go to PULSE_HI.
- PULSE_HI: cnt_trig=1 for PULSE_W cycles, then go to PULSE_LO.
- PULSE_LO (1 cycle): cnt_trig=0; expected ← expected+1 (mod 2^CNT_W); go to SETTLE.
- DONE (1 cycle): done=1, busy=0; go to IDLE.
- busy=1 in CLEAR, SETTLE, CHECK, PULSE_HI and PULSE_LO.
- Run length for target N: CLR_CYC + (N+1)·(SETTLE_CYC+1) + N·(PULSE_W+1) busy cycles, then 1 DONE cycle. Defaults, N=3 → 31 busy cycles.
- target=0: clear, settle, one CHECK, then DONE with no trigger pulses.
- stop=1 in any busy state:
  - Next cycle: state IDLE, cnt_trig=0, abort=1 for one cycle, done=0.
  - err keeps its value; sample keeps its last value.
- stop in IDLE or DONE is ignored. Simultaneous start and stop in IDLE: stop wins and no run starts.
- start while busy or in DONE is ignored; target changes after acceptance have no effect.
- No new trigger edge is issued before SETTLE_CYC has elapsed since the previous falling edge. The counter never sees more than one trigger per check.
- Reset asserted mid-run: immediate return to reset values, including cnt_trig=0 and cnt_rstn=0. No done or abort pulse.

Test Plan:
- Reset, then start with target=5 and a behavioural ripple counter attached → exactly 5 cnt_trig pulses each 2 cycles wide, sample=5, err=0. done pulses once, 1 cycle after the 47th busy cycle.
- target=0 → no cnt_trig pulses, cnt_rstn low for 2 cycles, sample=0, done after 7 busy cycles.
- target=15 → 15 pulses, sample=15, err=0. A follow-up run with target=2 clears the counter first and ends with sample=2.
- Force bit 1 of the counter model stuck at 0, target=3 → CHECK at expected=2 sees 0, err=1, done pulses, no further pulses. The next start clears err.
- stop asserted during the 2nd PULSE_HI → next cycle cnt_trig=0, abort=1, busy=0, done stays 0. Start+stop in the same IDLE cycle → busy stays 0.
- rstn asserted in SETTLE of a target=9 run → all outputs return to reset values at once (cnt_rstn=0). After release, IDLE with cnt_rstn=1.

Source files
------------

// File: rtl/ripple_cnt_seq.sv
`default_nettype none
// =============================================================================
// Module  : ripple_cnt_seq
// Brief   : Sequencer for an external negedge-T ripple counter. It clears the
//           counter, pulses its trigger, waits for the ripple to settle, then
//           samples the synchronized count and checks it.
// Rev     : 1.0  initial release
// =============================================================================
module ripple_cnt_seq #(
    parameter int CNT_W      = 4,
    parameter int PULSE_W    = 2,
    parameter int SETTLE_CYC = 4,
    parameter int CLR_CYC    = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] target_i,
    input  logic [CNT_W-1:0] cnt_in_i,
    output logic             cnt_trig_o,
    output logic             cnt_rstn_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             abort_o,
    output logic             err_o,
    output logic [CNT_W-1:0] sample_o
);

    // One shared down-the-line timer serves CLEAR, SETTLE and PULSE_HI.
    localparam int CYC_MAX = (CLR_CYC > SETTLE_CYC) ?
                             ((CLR_CYC > PULSE_W) ? CLR_CYC : PULSE_W) :
                             ((SETTLE_CYC > PULSE_W) ? SETTLE_CYC : PULSE_W);
    localparam int CYC_W   = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX);

    localparam logic [CYC_W-1:0] c_clr_last    = CYC_W'(CLR_CYC - 1);
    localparam logic [CYC_W-1:0] c_settle_last = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0] c_pulse_last  = CYC_W'(PULSE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_SETTLE   = 3'd2,
        S_CHECK    = 3'd3,
        S_PULSE_HI = 3'd4,
        S_PULSE_LO = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    state_e             state_q,    state_d;
    logic [CYC_W-1:0]   timer_q,    timer_d;
    logic [CNT_W-1:0]   expected_q, expected_d;
    logic [CNT_W-1:0]   target_q,   target_d;
    logic [CNT_W-1:0]   sample_q,   sample_d;
    logic               err_q,      err_d;
    logic               trig_q,     trig_d;
    logic               cnt_rstn_q, cnt_rstn_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               abort_q,    abort_d;

    logic [CNT_W-1:0]   w_cnt_sync;
    logic               w_busy_state;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer per counter bit; cnt_in_i is never used raw.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CNT_W; gi++) begin : g_sync
            logic [1:0] sync_q;

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    sync_q <= 2'b00;
                end else begin
                    sync_q <= {sync_q[0], cnt_in_i[gi]};
                end
            end

            assign w_cnt_sync[gi] = sync_q[1];
        end
    endgenerate

    assign w_busy_state = (state_q == S_CLEAR)    || (state_q == S_SETTLE)   ||
                          (state_q == S_CHECK)    || (state_q == S_PULSE_HI) ||
                          (state_q == S_PULSE_LO);

    // -------------------------------------------------------------------------
    // Next-state logic. Outputs are decoded from the next state so that the
    // registered outputs line up with the state they describe.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        expected_d = expected_q;
        target_d   = target_q;
        sample_d   = sample_q;
        err_d      = err_q;
        abort_d    = 1'b0;

        if (w_busy_state && stop_i) begin
            state_d = S_IDLE;
            timer_d = '0;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !stop_i) begin
                        target_d   = target_i;
                        err_d      = 1'b0;
                        expected_d = '0;
                        timer_d    = '0;
                        state_d    = S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    if (timer_q == c_clr_last) begin
                        timer_d = '0;
                        state_d = S_SETTLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (timer_q == c_settle_last) begin
                        timer_d = '0;
                        state_d = S_CHECK;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                S_CHECK: begin
                    sample_d = w_cnt_sync;
                    timer_d  = '0;
                    if (w_cnt_sync != expected_q) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (expected_q == target_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PULSE_HI;
                    end
                end

                S_PULSE_HI: begin
                    if (timer_q == c_pulse_last) begin
                        timer_d = '0;
                        state_d = S_PULSE_LO;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                // The counter steps on this falling trigger edge.
                S_PULSE_LO: begin
                    expected_d = expected_q + 1'b1;
                    timer_d    = '0;
                    state_d    = S_SETTLE;
                end

                S_DONE: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            endcase
        end

        trig_d     = (state_d == S_PULSE_HI);
        cnt_rstn_d = (state_d != S_CLEAR);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d == S_CLEAR)    || (state_d == S_SETTLE)   ||
                     (state_d == S_CHECK)    || (state_d == S_PULSE_HI) ||
                     (state_d == S_PULSE_LO);
    end

    // -------------------------------------------------------------------------
    // State and output registers. Reset holds the counter in reset as well.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            expected_q <= '0;
            target_q   <= '0;
            sample_q   <= '0;
            err_q      <= 1'b0;
            trig_q     <= 1'b0;
            cnt_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            expected_q <= expected_d;
            target_q   <= target_d;
            sample_q   <= sample_d;
            err_q      <= err_d;
            trig_q     <= trig_d;
            cnt_rstn_q <= cnt_rstn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign cnt_trig_o = trig_q;
    assign cnt_rstn_o = cnt_rstn_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign abort_o    = abort_q;
    assign err_o      = err_q;
    assign sample_o   = sample_q;

endmodule
`default_nettype wire

// File: tb/tb_ripple_cnt_seq.sv
`default_nettype none
// =============================================================================
// Module  : tb_ripple_cnt_seq
// Brief   : Bench for ripple_cnt_seq with a behavioural negedge ripple counter.
// Rev     : 1.0  initial release
// =============================================================================
module tb_ripple_cnt_seq;

    localparam int CNT_W      = 4;
    localparam int PULSE_W    = 2;
    localparam int SETTLE_CYC = 4;
    localparam int CLR_CYC    = 2;

    logic             clk    = 1'b0;
    logic             rstn   = 1'b0;
    logic             start  = 1'b0;
    logic             stop   = 1'b0;
    logic [CNT_W-1:0] target = '0;
    logic [CNT_W-1:0] cnt_in;
    logic             cnt_trig;
    logic             cnt_rstn;
    logic             busy;
    logic             done;
    logic             abort;
    logic             err;
    logic [CNT_W-1:0] sample;

    logic [CNT_W-1:0] ctr   = '0;
    logic [CNT_W-1:0] stuck = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ripple_cnt_seq #(
        .CNT_W      (CNT_W),
        .PULSE_W    (PULSE_W),
        .SETTLE_CYC (SETTLE_CYC),
        .CLR_CYC    (CLR_CYC)
    ) u_dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .start_i    (start),
        .stop_i     (stop),
        .target_i   (target),
        .cnt_in_i   (cnt_in),
        .cnt_trig_o (cnt_trig),
        .cnt_rstn_o (cnt_rstn),
        .busy_o     (busy),
        .done_o     (done),
        .abort_o    (abort),
        .err_o      (err),
        .sample_o   (sample)
    );

    // Behavioural ripple counter: advances on trigger falling edge, async clear.
    always @(negedge cnt_trig or negedge cnt_rstn) begin
        if (!cnt_rstn) ctr <= '0;
        else           ctr <= ctr + 1'b1;
    end

    assign #3 cnt_in = ctr & ~stuck;

    // Cumulative activity monitor, sampled just after each rising edge.
    int   busy_cyc  = 0;
    int   done_cnt  = 0;
    int   abort_cnt = 0;
    int   pulses    = 0;
    int   hi_w      = 0;
    int   bad_w     = 0;
    int   lo_gap    = 99;
    int   bad_gap   = 0;
    int   rlow      = 0;
    logic trig_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            trig_prev <= 1'b0;
            hi_w      <= 0;
            lo_gap    <= 99;
        end else begin
            busy_cyc  <= busy_cyc  + (busy ? 1 : 0);
            done_cnt  <= done_cnt  + (done ? 1 : 0);
            abort_cnt <= abort_cnt + (abort ? 1 : 0);
            rlow      <= rlow      + (cnt_rstn ? 0 : 1);
            if (cnt_trig) begin
                hi_w <= hi_w + 1;
                if (!trig_prev) begin
                    pulses <= pulses + 1;
                    if (lo_gap < SETTLE_CYC + 1) bad_gap <= bad_gap + 1;
                end
            end else if (trig_prev) begin
                if (hi_w != PULSE_W) bad_w <= bad_w + 1;
                hi_w   <= 0;
                lo_gap <= 1;
            end else begin
                lo_gap <= lo_gap + 1;
            end
            trig_prev <= cnt_trig;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: walk the expected counts, apply the stuck-at-0 mask to what the
    // sequencer would see, stop at the first mismatch or at the target.
    task automatic model(input int n, input int mask,
                         output int e_pulses, output int e_sample,
                         output int e_err, output int e_busy);
        e_pulses = 0;
        e_sample = 0;
        e_err    = 0;
        for (int k = 0; k <= n; k++) begin
            e_sample = k & ~mask & ((1 << CNT_W) - 1);
            if (e_sample != k) begin
                e_err = 1;
                break;
            end
            if (k == n) break;
            e_pulses++;
        end
        e_busy = CLR_CYC + (e_pulses + 1) * (SETTLE_CYC + 1) + e_pulses * (PULSE_W + 1);
    endtask

    task automatic do_run(input int n, input int mask, input bit noisy);
        int e_p, e_s, e_e, e_b;
        int b_busy, b_done, b_pul, b_bw, b_bg, b_rl, b_ab;
        int cyc;
        model(n, mask, e_p, e_s, e_e, e_b);
        @(negedge clk);
        stuck  = CNT_W'(mask);
        b_busy = busy_cyc; b_done = done_cnt; b_pul = pulses; b_ab = abort_cnt;
        b_bw   = bad_w;    b_bg   = bad_gap;  b_rl  = rlow;
        start  = 1'b1;
        target = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        check($sformatf("run%0d_busy_after_start", n), 32'(busy), 32'd1);
        check($sformatf("run%0d_err_cleared", n), 32'(err), 32'd0);
        cyc = 0;
        while (!done && cyc < 2000) begin
            if (noisy) begin
                start  = 1'($urandom_range(0, 1));
                target = CNT_W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check($sformatf("run%0d_done_seen", n), 32'(done), 32'd1);
        check($sformatf("run%0d_pulses", n), pulses - b_pul, e_p);
        check($sformatf("run%0d_sample", n), 32'(sample), e_s);
        check($sformatf("run%0d_err", n), 32'(err), e_e);
        check($sformatf("run%0d_busy_cycles", n), busy_cyc - b_busy, e_b);
        check($sformatf("run%0d_clr_cycles", n), rlow - b_rl, CLR_CYC);
        check($sformatf("run%0d_pulse_width", n), bad_w - b_bw, 0);
        check($sformatf("run%0d_pulse_gap", n), bad_gap - b_bg, 0);
        @(negedge clk);
        check($sformatf("run%0d_done_once", n), done_cnt - b_done, 1);
        check($sformatf("run%0d_done_low", n), 32'(done), 32'd0);
        check($sformatf("run%0d_idle", n), 32'(busy), 32'd0);
        check($sformatf("run%0d_no_abort", n), abort_cnt - b_ab, 0);
        stuck = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_pul, b_done, b_ab, cyc;

        // Reset state.
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_trig",  32'(cnt_trig), 32'd0);
        check("rst_crstn", 32'(cnt_rstn), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_abort", 32'(abort),    32'd0);
        check("rst_err",   32'(err),      32'd0);
        check("rst_sample",32'(sample),   32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_crstn", 32'(cnt_rstn), 32'd1);

        // Directed runs.
        do_run(5, 0, 1'b0);
        do_run(0, 0, 1'b0);
        do_run(15, 0, 1'b0);
        do_run(2, 0, 1'b0);

        // Bit 1 stuck at 0; err stays sticky, then the next run clears it.
        do_run(3, 2, 1'b0);
        @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        do_run(1, 0, 1'b0);

        // Randomized runs with start/target noise while busy.
        for (int i = 0; i < 6; i++) begin
            int n, m;
            n = $urandom_range(0, 15);
            m = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
            do_run(n, m, 1'b1);
        end

        // Stop during the second trigger pulse.
        @(negedge clk);
        b_pul = pulses; b_done = done_cnt; b_ab = abort_cnt;
        start = 1'b1; target = 4'd5;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!((pulses - b_pul) == 2 && cnt_trig) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("stop_reach_pulse2", pulses - b_pul, 2);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_trig",   32'(cnt_trig), 32'd0);
        check("stop_abort",  32'(abort),    32'd1);
        check("stop_busy",   32'(busy),     32'd0);
        check("stop_done",   32'(done),     32'd0);
        check("stop_sample", 32'(sample),   32'd1);
        check("stop_err",    32'(err),      32'd0);
        @(negedge clk);
        check("stop_abort_pulse", 32'(abort), 32'd0);
        check("stop_abort_once", abort_cnt - b_ab, 1);
        check("stop_no_done", done_cnt - b_done, 0);

        // Simultaneous start and stop in IDLE: nothing starts.
        start = 1'b1; stop = 1'b1; target = 4'd4;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("ss_busy",  32'(busy),     32'd0);
        check("ss_crstn", 32'(cnt_rstn), 32'd1);
        @(negedge clk);
        check("ss_busy2", 32'(busy),  32'd0);
        check("ss_abort", 32'(abort), 32'd0);

        // Reset asserted in SETTLE of a target=9 run.
        b_pul = pulses;
        start = 1'b1; target = 4'd9;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!((pulses - b_pul) == 1 && !cnt_trig) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        b_done = done_cnt; b_ab = abort_cnt;
        rstn = 1'b0;
        #1;
        check("mrst_trig",   32'(cnt_trig), 32'd0);
        check("mrst_crstn",  32'(cnt_rstn), 32'd0);
        check("mrst_busy",   32'(busy),     32'd0);
        check("mrst_done",   32'(done),     32'd0);
        check("mrst_abort",  32'(abort),    32'd0);
        check("mrst_err",    32'(err),      32'd0);
        check("mrst_sample", 32'(sample),   32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("mrst_idle_crstn", 32'(cnt_rstn), 32'd1);
        check("mrst_idle_busy",  32'(busy),     32'd0);
        check("mrst_no_done",  done_cnt - b_done, 0);
        check("mrst_no_abort", abort_cnt - b_ab,  0);

        // A clean run after the reset still works.
        do_run(4, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
